hilo_div_ctrl: RTL and testbench

Multicycle sequencer for the pipeline's combinational 32-bit divider and owner of the HI/LO register pair. It accepts DIV/DIVU/MTHI/MTLO from the EX stage, holds the divider operands stable for a fixed number of cycles so the long divider path closes as a multicycle path, stalls the pipeline meanwhile, and commits quotient to LO and remainder to HI. It sits beside the EX stage, between the decode/EX operand registers and the divider instance.

---
 rtl/hilo_div_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// ============================================================================
// Module   : hilo_div_ctrl
// Brief    : Multicycle sequencer for an external combinational 32-bit divider
//            and owner of the architectural HI/LO register pair. Accepts
//            DIV/DIVU/MTHI/MTLO, holds divider operands stable for DIV_CYCLES
//            cycles while stalling the pipeline, then commits quotient to LO
//            and remainder to HI.
// Option   : DIV_ZERO_FAST_EN - when defined, a divide by zero skips the
//            multicycle path and commits LO=all-ones, HI=dividend next edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_div_ctrl #(
  parameter int DIV_CYCLES = 4
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_rs,
  input  logic [31:0] op_rt,
  input  logic        flush,
  output logic        op_ready,
  output logic        stall,
  output logic        div_ena,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  // Operation encodings seen on op_code
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  // Counter must hold DIV_CYCLES-1; one extra bit keeps DIV_CYCLES=1 legal
  localparam int              CNT_W    = $clog2(DIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      div_a_q;
  logic [31:0]      div_b_q;
  logic             div_sign_q;
  logic             div_ena_q;
  logic             done_q;

  // Decoded request qualifiers for the IDLE state
  logic is_div_d;
  logic is_mthi_d;
  logic is_mtlo_d;
  logic div_by_zero_d;

  // Decode the incoming op; flush suppresses everything presented that cycle
  always_comb begin
    is_div_d      = op_valid && !flush && ((op_code == OP_DIV) || (op_code == OP_DIVU));
    is_mthi_d     = op_valid && !flush && (op_code == OP_MTHI);
    is_mtlo_d     = op_valid && !flush && (op_code == OP_MTLO);
    div_by_zero_d = (op_rt == 32'd0);
  end

  // Sequencer: owns state, cycle counter, operand latches and HI/LO
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      div_a_q    <= 32'd0;
      div_b_q    <= 32'd0;
      div_sign_q <= 1'b0;
      div_ena_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless re-armed below
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (is_div_d) begin
`ifdef DIV_ZERO_FAST_EN
            if (div_by_zero_d) begin
              // Zero divisor resolves immediately; divider is never engaged
              lo_q   <= 32'hFFFF_FFFF;
              hi_q   <= op_rs;
              done_q <= 1'b1;
            end else begin
              div_a_q    <= op_rs;
              div_b_q    <= op_rt;
              div_sign_q <= (op_code == OP_DIVU);
              div_ena_q  <= 1'b1;
              cnt_q      <= CNT_INIT;
              state_q    <= S_BUSY;
            end
`else
            // Zero divisor follows the normal path; the divider decides the result
            div_a_q    <= op_rs;
            div_b_q    <= op_rt;
            div_sign_q <= (op_code == OP_DIVU);
            div_ena_q  <= 1'b1;
            cnt_q      <= CNT_INIT;
            state_q    <= S_BUSY;
`endif
          end else if (is_mthi_d) begin
            hi_q <= op_rs;
          end else if (is_mtlo_d) begin
            lo_q <= op_rs;
          end
        end
        S_BUSY: begin
          // Operands stay frozen here; new ops are ignored while stalled
          if (flush) begin
            // Flush beats a same-cycle commit: abandon the result entirely
            div_ena_q <= 1'b0;
            cnt_q     <= CNT_ZERO;
            state_q   <= S_IDLE;
          end else if (cnt_q == CNT_ZERO) begin
            lo_q      <= div_q;
            hi_q      <= div_r;
            div_ena_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          div_ena_q <= 1'b0;
        end
      endcase
    end
  end

  // Handshake outputs follow the state directly so the hold starts on accept
  always_comb begin
    stall    = (state_q == S_BUSY);
    op_ready = (state_q == S_IDLE);
  end

  assign div_ena  = div_ena_q;
  assign div_sign = div_sign_q;
  assign div_a    = div_a_q;
  assign div_b    = div_b_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;

  // div_by_zero_d is only consumed when the fast path is compiled in
  logic unused_d;
  assign unused_d = div_by_zero_d;

endmodule

`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
`default_nettype none

module tb_hilo_div_ctrl;

  logic        in_clk;
  logic        in_rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_rs;
  logic [31:0] op_rt;
  logic        flush;
  logic        op_ready;
  logic        stall;
  logic        div_ena;
  logic        div_sign;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  hilo_div_ctrl #(.DIV_CYCLES(4)) u_dut (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .op_valid(op_valid),
    .op_code (op_code),
    .op_rs   (op_rs),
    .op_rt   (op_rt),
    .flush   (flush),
    .op_ready(op_ready),
    .stall   (stall),
    .div_ena (div_ena),
    .div_sign(div_sign),
    .div_a   (div_a),
    .div_b   (div_b),
    .div_q   (div_q),
    .div_r   (div_r),
    .hi      (hi),
    .lo      (lo),
    .done    (done)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Behavioural stand-in for the combinational divider; fixed pattern on /0
  always_comb begin
    div_q = 32'hDEAD_BEEF;
    div_r = 32'hCAFE_F00D;
    if (div_b != 32'd0) begin
      if (div_sign) begin
        div_q = div_a / div_b;
        div_r = div_a % div_b;
      end else begin
        div_q = $signed(div_a) / $signed(div_b);
        div_r = $signed(div_a) % $signed(div_b);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] code, input logic [31:0] rs, input logic [31:0] rt);
    op_valid = 1'b1;
    op_code  = code;
    op_rs    = rs;
    op_rt    = rt;
  endtask

  task automatic idle_op();
    op_valid = 1'b0;
    op_code  = 3'd0;
    op_rs    = 32'd0;
    op_rt    = 32'd0;
  endtask

  initial begin
    in_rst = 1'b1;
    flush  = 1'b0;
    idle_op();
    tick();
    tick();
    in_rst = 1'b0;

    // Reset values
    check_val("rst_hi", hi, 32'd0);
    check_val("rst_lo", lo, 32'd0);
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_ready", {31'd0, op_ready}, 32'd1);
    check_val("rst_ena", {31'd0, div_ena}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_diva", div_a, 32'd0);

    // DIVU 100/7: four stall cycles, then LO=14 HI=2
    drive_op(3'd2, 32'd100, 32'd7);
    tick();
    idle_op();
    check_val("divu_sign", {31'd0, div_sign}, 32'd1);
    check_val("divu_ena", {31'd0, div_ena}, 32'd1);
    check_val("divu_ready", {31'd0, op_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("divu_stall%0d", i), {31'd0, stall}, 32'd1);
      check_val($sformatf("divu_hold_a%0d", i), div_a, 32'd100);
      check_val($sformatf("divu_hold_b%0d", i), div_b, 32'd7);
      check_val($sformatf("divu_nodone%0d", i), {31'd0, done}, 32'd0);
      tick();
    end
    check_val("divu_lo", lo, 32'd14);
    check_val("divu_hi", hi, 32'd2);
    check_val("divu_done", {31'd0, done}, 32'd1);
    check_val("divu_stall_end", {31'd0, stall}, 32'd0);
    check_val("divu_ready_end", {31'd0, op_ready}, 32'd1);
    check_val("divu_ena_end", {31'd0, div_ena}, 32'd0);

    // Back-to-back: signed DIV -7/2 accepted in the done cycle
    drive_op(3'd1, 32'hFFFF_FFF9, 32'd2);
    tick();
    idle_op();
    check_val("div_sign", {31'd0, div_sign}, 32'd0);
    check_val("div_stall", {31'd0, stall}, 32'd1);
    check_val("div_done_clr", {31'd0, done}, 32'd0);
    tick(); tick(); tick();
    check_val("div_pre_lo", lo, 32'd14);
    tick();
    check_val("div_lo", lo, 32'hFFFF_FFFD);
    check_val("div_hi", hi, 32'hFFFF_FFFF);
    check_val("div_done", {31'd0, done}, 32'd1);
    tick();
    check_val("div_done_pulse", {31'd0, done}, 32'd0);

    // MTHI then MTLO on consecutive cycles, no stall
    drive_op(3'd3, 32'h1234, 32'd0);
    tick();
    check_val("mthi_hi", hi, 32'h1234);
    check_val("mthi_stall", {31'd0, stall}, 32'd0);
    drive_op(3'd4, 32'h5678, 32'd0);
    tick();
    idle_op();
    check_val("mtlo_lo", lo, 32'h5678);
    check_val("mtlo_hi", hi, 32'h1234);
    check_val("mtlo_stall", {31'd0, stall}, 32'd0);

    // Flush in IDLE drops the op presented that cycle
    drive_op(3'd3, 32'hBAD0, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_op();
    check_val("idle_flush_hi", hi, 32'h1234);

    // DIVU 100/7 flushed in second BUSY cycle
    drive_op(3'd2, 32'd100, 32'd7);
    tick();
    idle_op();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("flush_stall", {31'd0, stall}, 32'd0);
    check_val("flush_ready", {31'd0, op_ready}, 32'd1);
    check_val("flush_ena", {31'd0, div_ena}, 32'd0);
    check_val("flush_hi", hi, 32'h1234);
    check_val("flush_lo", lo, 32'h5678);
    check_val("flush_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val($sformatf("flush_nodone%0d", i), {31'd0, done}, 32'd0);
    end
    check_val("flush_lo_late", lo, 32'h5678);

    // DIVU 5/0
    drive_op(3'd2, 32'd5, 32'd0);
    tick();
    idle_op();
`ifdef DIV_ZERO_FAST_EN
    check_val("dz_lo", lo, 32'hFFFF_FFFF);
    check_val("dz_hi", hi, 32'd5);
    check_val("dz_stall", {31'd0, stall}, 32'd0);
    check_val("dz_ena", {31'd0, div_ena}, 32'd0);
    check_val("dz_done", {31'd0, done}, 32'd1);
    tick();
    check_val("dz_done_clr", {31'd0, done}, 32'd0);
`else
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("dz_stall%0d", i), {31'd0, stall}, 32'd1);
      tick();
    end
    check_val("dz_lo", lo, 32'hDEAD_BEEF);
    check_val("dz_hi", hi, 32'hCAFE_F00D);
    check_val("dz_done", {31'd0, done}, 32'd1);
    tick();
`endif

    // Reset mid-BUSY aborts with no commit
    drive_op(3'd2, 32'd9, 32'd3);
    tick();
    idle_op();
    tick();
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    check_val("mrst_stall", {31'd0, stall}, 32'd0);
    check_val("mrst_hi", hi, 32'd0);
    check_val("mrst_lo", lo, 32'd0);
    check_val("mrst_ena", {31'd0, div_ena}, 32'd0);
    check_val("mrst_diva", div_a, 32'd0);
    check_val("mrst_done", {31'd0, done}, 32'd0);

    // Fresh DIVU 9/3 after reset
    drive_op(3'd2, 32'd9, 32'd3);
    tick();
    idle_op();
    tick(); tick(); tick(); tick();
    check_val("post_lo", lo, 32'd3);
    check_val("post_hi", hi, 32'd0);
    check_val("post_done", {31'd0, done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
